// File: rtl/pll_lock_monitor.sv
// ---------------------------------------------------------------------------
// pll_lock_monitor
//
// Lock detector for the ADPLL, running in the clk_ref domain. Once per
// reference clock it samples the phase detector's lead/lag flags and the DCO
// control word, classifies the cycle as good or bad and runs a small
// IDLE / ACQ / LOCKED state machine.
//
// A cycle is bad when the PD reports the same non-NONE direction twice in a
// row (the loop is not dithering around the reference); every other cycle is
// good. LOCK_CYCLES consecutive good cycles in ACQ declare lock,
// UNLOCK_CYCLES consecutive bad cycles in LOCKED drop it.
//
// Optional feature (macro ALPHA_TRACK_EN): while locked, a control word that
// drifts more than ALPHA_TOL away from the word captured at lock entry
// forces an immediate unlock.
//
// Ports:
//   clk        in   reference clock
//   rst_n      in   asynchronous active-low reset
//   enable     in   monitor enable; low returns the monitor to IDLE
//   lead       in   PD flag, DCO leads the reference this cycle
//   lag        in   PD flag, DCO lags the reference this cycle
//   alpha      in   DCO control word (ALPHA_W bits)
//   lock       out  loop locked (registered)
//   lock_lost  out  one-cycle pulse on LOCKED -> ACQ
//   alpha_lock out  alpha captured on lock entry
//   acq_cycles out  cycles spent acquiring since enable rose, saturating
// ---------------------------------------------------------------------------
module pll_lock_monitor #(
    parameter int unsigned LOCK_CYCLES   = 32,
    parameter int unsigned UNLOCK_CYCLES = 4,
    parameter int unsigned ALPHA_W       = 4,
    parameter int unsigned ALPHA_TOL     = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               lead,
    input  logic               lag,
    input  logic [ALPHA_W-1:0] alpha,
    output logic               lock,
    output logic               lock_lost,
    output logic [ALPHA_W-1:0] alpha_lock,
    output logic [15:0]        acq_cycles
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DN   = 2'd2
    } dir_t;

    localparam logic [7:0] LOCK_CNT   = 8'(LOCK_CYCLES);
    localparam logic [3:0] UNLOCK_CNT = 4'(UNLOCK_CYCLES);

    state_t             state_q,      state_d;
    dir_t               prev_dir_q,   prev_dir_d;
    logic [7:0]         good_cnt_q,   good_cnt_d;
    logic [3:0]         bad_run_q,    bad_run_d;
    logic               lock_q,       lock_d;
    logic               lock_lost_q,  lock_lost_d;
    logic [ALPHA_W-1:0] alpha_lock_q, alpha_lock_d;
    logic [15:0]        acq_q,        acq_d;

    dir_t               dir_s;
    logic               bad_s;
    logic               track_s;
    logic [7:0]         good_inc_s;
    logic [3:0]         bad_inc_s;

`ifdef ALPHA_TRACK_EN
    localparam logic [ALPHA_W:0] TOL_EXT = (ALPHA_W+1)'(ALPHA_TOL);

    // Unsigned |a - b| one bit wider than the control word.
    function automatic logic [ALPHA_W:0] abs_diff(input logic [ALPHA_W-1:0] a,
                                                  input logic [ALPHA_W-1:0] b);
        logic [ALPHA_W:0] a_ext;
        logic [ALPHA_W:0] b_ext;
        a_ext = {1'b0, a};
        b_ext = {1'b0, b};
        if (a_ext >= b_ext) begin
            abs_diff = a_ext - b_ext;
        end else begin
            abs_diff = b_ext - a_ext;
        end
    endfunction

    // Drift of the control word away from the captured lock value.
    always_comb begin
        track_s = (abs_diff(alpha, alpha_lock_q) > TOL_EXT);
    end
`else
    // Control-word tracking is not built; alpha only feeds the capture.
    always_comb begin
        track_s = 1'b0;
    end
`endif

    // Direction decode and good/bad classification of the current cycle.
    always_comb begin
        dir_s = DIR_NONE;
        if (lead && !lag) begin
            dir_s = DIR_UP;
        end else if (lag && !lead) begin
            dir_s = DIR_DN;
        end else begin
            dir_s = DIR_NONE;
        end
        bad_s      = (dir_s != DIR_NONE) && (dir_s == prev_dir_q);
        good_inc_s = good_cnt_q + 8'd1;
        bad_inc_s  = bad_s ? (bad_run_q + 4'd1) : 4'd0;
    end

    // Next-state and output logic of the lock FSM.
    always_comb begin
        state_d      = state_q;
        prev_dir_d   = prev_dir_q;
        good_cnt_d   = good_cnt_q;
        bad_run_d    = bad_run_q;
        lock_d       = lock_q;
        lock_lost_d  = 1'b0;
        alpha_lock_d = alpha_lock_q;
        acq_d        = acq_q;

        if (!enable) begin
            // Disable wins over everything, including a pending unlock.
            state_d    = ST_IDLE;
            prev_dir_d = DIR_NONE;
            good_cnt_d = 8'd0;
            bad_run_d  = 4'd0;
            lock_d     = 1'b0;
            acq_d      = 16'd0;
        end else begin
            prev_dir_d = dir_s;
            case (state_q)
                // The cycle in which enable is first seen already counts as
                // an acquisition cycle, so IDLE shares the ACQ behaviour.
                ST_IDLE, ST_ACQ: begin
                    state_d   = ST_ACQ;
                    bad_run_d = 4'd0;
                    if (acq_q != 16'hFFFF) begin
                        acq_d = acq_q + 16'd1;
                    end else begin
                        acq_d = acq_q;
                    end
                    if (bad_s) begin
                        good_cnt_d = 8'd0;
                    end else if (good_inc_s == LOCK_CNT) begin
                        state_d      = ST_LOCKED;
                        lock_d       = 1'b1;
                        alpha_lock_d = alpha;
                        good_cnt_d   = 8'd0;
                    end else begin
                        good_cnt_d = good_inc_s;
                    end
                end
                ST_LOCKED: begin
                    if ((bad_inc_s == UNLOCK_CNT) || track_s) begin
                        state_d     = ST_ACQ;
                        lock_d      = 1'b0;
                        lock_lost_d = 1'b1;
                        good_cnt_d  = 8'd0;
                        bad_run_d   = 4'd0;
                    end else begin
                        bad_run_d = bad_inc_s;
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    good_cnt_d = 8'd0;
                    bad_run_d  = 4'd0;
                    lock_d     = 1'b0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            prev_dir_q   <= DIR_NONE;
            good_cnt_q   <= 8'd0;
            bad_run_q    <= 4'd0;
            lock_q       <= 1'b0;
            lock_lost_q  <= 1'b0;
            alpha_lock_q <= '0;
            acq_q        <= 16'd0;
        end else begin
            state_q      <= state_d;
            prev_dir_q   <= prev_dir_d;
            good_cnt_q   <= good_cnt_d;
            bad_run_q    <= bad_run_d;
            lock_q       <= lock_d;
            lock_lost_q  <= lock_lost_d;
            alpha_lock_q <= alpha_lock_d;
            acq_q        <= acq_d;
        end
    end

    assign lock       = lock_q;
    assign lock_lost  = lock_lost_q;
    assign alpha_lock = alpha_lock_q;
    assign acq_cycles = acq_q;

endmodule

// File: tb/tb_pll_lock_monitor.sv
// ---------------------------------------------------------------------------
// Testbench for pll_lock_monitor. A driver applies directed and random
// stimulus on the falling edge, steps a behavioural reference model and
// queues the outputs expected after the next rising edge; a monitor pops and
// compares them one step after every rising edge. Directed scenarios add
// fixed-value checks of the documented behaviour.
// ---------------------------------------------------------------------------
module tb_pll_lock_monitor;

    localparam int LOCK_CYCLES   = 32;
    localparam int UNLOCK_CYCLES = 4;
    localparam int ALPHA_TOL     = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       lead = 1'b0;
    logic       lag = 1'b0;
    logic [3:0] alpha = 4'd0;
    logic       lock;
    logic       lock_lost;
    logic [3:0] alpha_lock;
    logic [15:0] acq_cycles;

    pll_lock_monitor #(
        .LOCK_CYCLES  (LOCK_CYCLES),
        .UNLOCK_CYCLES(UNLOCK_CYCLES),
        .ALPHA_W      (4),
        .ALPHA_TOL    (ALPHA_TOL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .lead      (lead),
        .lag       (lag),
        .alpha     (alpha),
        .lock      (lock),
        .lock_lost (lock_lost),
        .alpha_lock(alpha_lock),
        .acq_cycles(acq_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        int lock;
        int lost;
        int alock;
        int acq;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: plain integers, direction as -1/0/+1.
    bit m_active;   // acquiring or locked (not idle)
    bit m_locked;
    int m_good, m_bad, m_prev, m_acq, m_alock;
    bit m_lost;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_step(input bit r, input bit en, input bit ld,
                                       input bit lg, input int al);
        int d;
        bit bad;
        bit drift;
        m_lost = 1'b0;
        if (!r) begin
            m_active = 0; m_locked = 0; m_good = 0; m_bad = 0;
            m_prev = 0; m_acq = 0; m_alock = 0;
        end else if (!en) begin
            m_active = 0; m_locked = 0; m_good = 0; m_bad = 0;
            m_prev = 0; m_acq = 0;
        end else begin
            d = (ld && !lg) ? 1 : ((lg && !ld) ? -1 : 0);
            bad = (d != 0) && (d == m_prev);
            m_prev = d;
            m_active = 1;
            if (!m_locked) begin
                if (m_acq < 65535) m_acq = m_acq + 1;
                m_good = bad ? 0 : m_good + 1;
                if (m_good == LOCK_CYCLES) begin
                    m_locked = 1; m_alock = al; m_good = 0;
                end
            end else begin
`ifdef ALPHA_TRACK_EN
                drift = ((al > m_alock) ? al - m_alock : m_alock - al) > ALPHA_TOL;
`else
                drift = 1'b0;
`endif
                m_bad = bad ? m_bad + 1 : 0;
                if (m_bad == UNLOCK_CYCLES || drift) begin
                    m_locked = 0; m_lost = 1; m_bad = 0; m_good = 0;
                end
            end
        end
    endfunction

    // One reference-clock cycle of stimulus plus its queued expectation.
    task automatic cycle(input bit r, input bit en, input bit ld, input bit lg,
                         input int al);
        exp_t e;
        @(negedge clk);
        rst_n  = r;
        enable = en;
        lead   = ld;
        lag    = lg;
        alpha  = 4'(al);
        model_step(r, en, ld, lg, al);
        e.lock  = m_locked;
        e.lost  = m_lost;
        e.alock = m_alock;
        e.acq   = m_acq;
        exp_q.push_back(e);
    endtask

    // n alternating lead/lag cycles, starting with lead when first_lead=1.
    task automatic alt(input int n, input bit first_lead, input int al);
        for (int i = 0; i < n; i++) begin
            cycle(1'b1, 1'b1, first_lead ^ 1'(i % 2), ~(first_lead ^ 1'(i % 2)), al);
        end
    endtask

    // Wait until just after the edge that consumed the last cycle() call.
    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: compare queued expectations one step after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_lock",       int'(lock),       e.lock);
                chk("sb_lock_lost",  int'(lock_lost),  e.lost);
                chk("sb_alpha_lock", int'(alpha_lock), e.alock);
                chk("sb_acq_cycles", int'(acq_cycles), e.acq);
            end
        end
    end

    initial begin
        bit altb;
        bit r, en, ld, lg;
        int al;
        model_step(1'b0, 1'b0, 1'b0, 1'b0, 0);

        // Reset held until 550 ns, then 10 idle cycles with random inputs.
        for (int i = 0; i < 54; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 10; i++)
            cycle(1'b1, 1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)),
                  int'($urandom_range(15)));
        settle();
        chk("idle_lock", int'(lock), 0);
        chk("idle_acq", int'(acq_cycles), 0);
        chk("idle_alpha_lock", int'(alpha_lock), 0);

        // Acquisition: 5 leads then 32 alternating cycles (lag first), alpha=9.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, 9);
        alt(31, 1'b0, 9);
        settle();
        chk("acq_not_yet_locked", int'(lock), 0);
        alt(1, 1'b1, 9);
        settle();
        chk("acq_lock", int'(lock), 1);
        chk("acq_cycles_37", int'(acq_cycles), 37);
        chk("acq_alpha_lock", int'(alpha_lock), 9);
        alt(3, 1'b0, 9);
        settle();
        chk("acq_frozen", int'(acq_cycles), 37);

        // Unlock: last dir was lag; five leads -> 4 consecutive bad cycles.
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, 9);
        settle();
        chk("unlock_still_locked", int'(lock), 1);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 9);
        settle();
        chk("unlock_pulse", int'(lock_lost), 1);
        chk("unlock_lock", int'(lock), 0);
        chk("unlock_acq_held", int'(acq_cycles), 37);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 9);
        settle();
        chk("unlock_pulse_single", int'(lock_lost), 0);
        chk("unlock_acq_resumes", int'(acq_cycles), 38);

        // Good-count restart: 31 alternating, lag, lag, then 32 alternating.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 9);
        settle();
        chk("disable_acq_clear", int'(acq_cycles), 0);
        alt(31, 1'b0, 9);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 9);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 9);
        settle();
        chk("restart_no_lock", int'(lock), 0);
        alt(31, 1'b1, 9);
        settle();
        chk("restart_not_yet", int'(lock), 0);
        alt(1, 1'b0, 9);
        settle();
        chk("restart_lock", int'(lock), 1);

        // Control word drift while locked (last dir was lag).
        alt(1, 1'b1, 10);
        settle();
        chk("alpha10_locked", int'(lock), 1);
        alt(1, 1'b0, 11);
        settle();
`ifdef ALPHA_TRACK_EN
        chk("alpha11_unlock_pulse", int'(lock_lost), 1);
        chk("alpha11_unlock_lock", int'(lock), 0);
`else
        chk("alpha11_no_pulse", int'(lock_lost), 0);
        chk("alpha11_stays_locked", int'(lock), 1);
`endif
        alt(1, 1'b1, 9);
        settle();
        chk("alpha_pulse_single", int'(lock_lost), 0);
        alt(31, 1'b0, 9);
        settle();
        chk("relock", int'(lock), 1);

        // Enable drops in the cycle that would be the 4th bad cycle.
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, 9);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 9);
        settle();
        chk("disable_wins_no_pulse", int'(lock_lost), 0);
        chk("disable_wins_lock", int'(lock), 0);
        chk("disable_wins_acq", int'(acq_cycles), 0);

        // lead=lag=1 counts as NONE, i.e. good.
        for (int i = 0; i < 31; i++) cycle(1'b1, 1'b1, 1'b1, 1'b1, 5);
        settle();
        chk("both_high_not_yet", int'(lock), 0);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 5);
        settle();
        chk("both_high_lock", int'(lock), 1);
        chk("both_high_acq", int'(acq_cycles), 32);
        chk("both_high_alpha", int'(alpha_lock), 5);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 1'b1, 1'b1, 5);

        // Mid-operation reset.
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 5);
        settle();
        chk("midreset_lock", int'(lock), 0);
        chk("midreset_alpha", int'(alpha_lock), 0);

        // Random phase, biased toward dithering so that lock is reached.
        altb = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            r  = ($urandom_range(999) != 0);
            en = ($urandom_range(299) != 0);
            if ($urandom_range(19) < 17) begin
                altb = ~altb;
                ld = altb;
                lg = ~altb;
            end else begin
                ld = 1'($urandom_range(1));
                lg = 1'($urandom_range(1));
            end
            al = ($urandom_range(9) < 8) ? 9 : int'($urandom_range(15));
            cycle(r, en, ld, lg, al);
        end

        settle();
        #2;
        chk("queue_drain", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pll_lock_monitor.md
Name: pll_lock_monitor

Overview:
- Consumer end of the ADPLL phase-detector interface: samples the PD's lead/lag flags and the DCO control word alpha once per reference clock.
- Decides whether the loop has locked, lost lock, and how long acquisition took.
- Sits beside the PLL core in the clk_ref domain; drives the lock status used by system control and by the gate-level bench.

Parameters:
- LOCK_CYCLES, 32: consecutive good cycles required to declare lock (2..255).
- UNLOCK_CYCLES, 4: consecutive bad cycles in LOCKED that drop lock (1..15).
- ALPHA_W, 4: width of the DCO control word.
- ALPHA_TOL, 1: allowed |alpha - alpha_lock| while locked (used only with the optional feature).

Ports:
- clk  input  1  reference clock (clk_ref domain).
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  monitor enable, synchronous to clk.
- lead  input  1  PD flag: DCO leads reference this cycle, synchronous to clk.
- lag  input  1  PD flag: DCO lags reference this cycle, synchronous to clk.
- alpha  input  ALPHA_W  current DCO control word.
- lock  output  1  loop locked (registered).
- lock_lost  output  1  one-cycle pulse on LOCKED->ACQ transition.
- alpha_lock  output  ALPHA_W  alpha captured on lock entry.
- acq_cycles  output  16  cycles spent in ACQ since enable rose; saturating.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous active-low; assertion clears everything immediately.
- Reset values: lock=0, lock_lost=0, alpha_lock=0, acq_cycles=0, state=IDLE, prev_dir=NONE, good_cnt=0, bad_run=0.
- Direction decode: lead&~lag = UP; lag&~lead = DN; neither or both = NONE.
- Cycle classification: a cycle is bad when dir is not NONE and dir equals prev_dir (the registered dir of the immediately previous cycle). Every other cycle is good. prev_dir updates every enabled cycle.
- FSM IDLE:
  - Entered whenever enable=0, on the next clock and from any state.
  - Clears good_cnt, bad_run, prev_dir, lock and acq_cycles. alpha_lock holds its value.
  - No lock_lost pulse on this exit.
  - enable=1 -> ACQ.
- FSM ACQ:
  - acq_cycles increments by 1 per cycle and saturates at 0xFFFF.
  - Good cycle: good_cnt++. Bad cycle: good_cnt=0.
  - When the sampled cycle makes good_cnt reach LOCK_CYCLES: next state LOCKED, lock=1 on the following edge, alpha_lock <= alpha from that same cycle, good_cnt=0.
- FSM LOCKED:
  - acq_cycles is frozen.
  - Good cycle: bad_run=0. Bad cycle: bad_run++.
  - When bad_run reaches UNLOCK_CYCLES: next state ACQ, lock=0, lock_lost=1 for exactly one cycle, good_cnt=0, bad_run=0.
  - acq_cycles is not cleared on relock; it resumes counting.
- Latency: lock rises on the clock edge that samples the LOCK_CYCLES-th good cycle, so it is visible the cycle after.
- Simultaneous events: enable falling in the same cycle as the unlock condition -> IDLE wins, no lock_lost pulse.
- Mid-operation reset: asynchronous clear to the reset values; the FSM restarts from IDLE.

Optional Feature:
- Macro ALPHA_TRACK_EN.
- Defined: while LOCKED, any cycle with |alpha - alpha_lock| > ALPHA_TOL forces an immediate unlock on the next edge (lock=0, one-cycle lock_lost pulse, state ACQ), regardless of bad_run. The difference is computed unsigned at ALPHA_W+1 bits.
- Undefined: alpha affects only alpha_lock capture. The comparison logic is absent.

Test Plan:
- Reset and idle: rst_n=0 for 550 ns, then enable=0 for 10 cycles -> lock=0, lock_lost=0, acq_cycles=0, alpha_lock=0 throughout.
- Acquisition: enable=1; lead for 5 cycles, then alternating lead/lag for 32 cycles, alpha=9 -> acq_cycles=37 then frozen, lock=1 visible in cycle 38, alpha_lock=9.
- Good-count reset: in ACQ, 31 alternating cycles then lag,lag -> good_cnt restarts and lock stays 0; 32 further alternating cycles -> lock=1.
- Unlock: from LOCKED, lead held for 5 cycles -> lock_lost pulses exactly once, on the edge that samples the 5th lead cycle (4 consecutive bad), lock=0, acq_cycles resumes counting.
- Boundaries: enable dropped in the same cycle as the 4th bad cycle -> state IDLE, no lock_lost pulse. lead=lag=1 for 40 cycles in ACQ -> treated as NONE, so lock after 32.
- ALPHA_TRACK_EN built: locked with alpha_lock=9; alpha=11 for one cycle -> unlock with a one-cycle lock_lost pulse. alpha=10 -> stays locked. Without the macro, alpha=11 -> stays locked.
